stop_watch_gen: RTL and testbench
=================================

Name: stop_watch_gen

Overview:
Parametrised N-digit BCD stopwatch/timer. It is the successor to the fixed 3-digit up-only stopwatch.
- Prescaler divides clk by DVSR to produce a count tick.
- Tick drives a cascaded BCD digit chain that counts up or down, with parallel preset.
- Lap/split freeze of the displayed value; overflow and zero flags.
- Output feeds the 7-segment display multiplexer.

Parameters:
DVSR, 5000000, clk cycles per count tick (>=2); prescaler width = $clog2(DVSR)
NDIG, 4, number of BCD digits (1..8)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
go  in  1  1 = run (prescaler advances), 0 = pause (prescaler and digits hold)
clr  in  1  synchronous clear of digits, prescaler and lap state
up  in  1  count direction: 1 = up, 0 = down
ld  in  1  synchronous load of din into digits; prescaler cleared
din  in  4*NDIG  preset value, digit i at bits [4i+3:4i]
lap  in  1  single-cycle pulse; toggles display freeze (LAP_EN only)
d  out  4*NDIG  displayed BCD value, digit 0 = LSD at bits [3:0]
ovf  out  1  one-cycle pulse on up-count wrap from all-9s to all-0s
zero  out  1  level; 1 when the live count is all zeros

Behaviour:
- Reset (async, any time including mid-count or mid-freeze):
  - prescaler = 0, all digits = 0, ovf = 0, frozen = 0, lap register = 0.
  - Outputs: d = 0, ovf = 0, zero = 1.
- Priority per clock edge: clr > ld > tick.
- Prescaler:
  - Counts 0..DVSR-1 while go = 1; holds while go = 0.
  - tick = go && (prescaler == DVSR-1); prescaler wraps to 0 on the same edge.
  - Exactly one tick per DVSR go-cycles.
- clr: digits = 0, prescaler = 0, frozen = 0; ovf = 0 that cycle. Any coincident tick or ld is discarded.
- ld (clr = 0): each digit = din digit, with values >9 clamped to 9; prescaler = 0. A coincident tick is discarded.
- Tick, up = 1:
  - Digit 0 increments; a digit at 9 goes to 0 and carries to the next digit.
  - All 9s -> all 0s and ovf = 1 for exactly one cycle, aligned with the cycle d shows all 0s.
- Tick, up = 0:
  - Digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
  - At all zeros the tick is ignored: the count saturates and holds, zero stays 1, ovf never asserts.
- Latency:
  - Digits update on the edge that samples tick; visible on d in the next cycle (live display).
  - zero is combinational from the digit registers.
- up changing mid-count takes effect from the next tick. The prescaler phase is not disturbed.
- ovf is registered and is 0 in every cycle except the wrap cycle.
- Digit chain is generate-based over NDIG. No combinational path from inputs to d.

Optional Feature:
Macro STOP_WATCH_GEN_LAP_EN.
- Defined:
  - A lap pulse while not frozen captures the live count into the lap register and sets frozen = 1.
  - While frozen, d shows the lap register and counting continues underneath.
  - A lap pulse while frozen clears frozen, and d returns to the live count the next cycle.
  - clr and reset clear frozen.
  - lap coincident with clr: clr wins and frozen = 0.
  - lap coincident with a tick captures the pre-tick value.
  - ovf and zero always reflect the live count.
- Undefined: lap is ignored, no lap register is synthesised, and d is always the live count.

Test Plan:
- DVSR=4, NDIG=3:
  - Reset, then go=1 up=1 for 40 cycles -> d=0x010, zero=0 after the first tick, ovf never high.
  - ld din=0x999 up=1 go=1, wait 4 cycles -> d=0x000, ovf high exactly 1 cycle, zero=1.
  - ld din=0x010 up=0 go=1 -> 4 cycles later d=0x009; 40 cycles later d=0x000, zero=1; 20 more cycles d stays 0x000, ovf=0.
  - ld din=0x0A5 -> d=0x095 (clamp); go=0 for 50 cycles -> d unchanged.
  - clr and tick in the same cycle while d=0x123 -> d=0x000, prescaler=0, next tick arrives 4 go-cycles later.
  - LAP_EN: run up to d=0x005, pulse lap -> d holds 0x005 for 20 cycles; pulse lap again -> d=0x00A. Assert reset mid-count -> d=0x000 asynchronously.

Source files
------------

// File: rtl/stop_watch_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stop_watch_gen: N-digit BCD up/down stopwatch with prescaler, preset,    |
// | overflow/zero flags and optional lap freeze (STOP_WATCH_GEN_LAP_EN).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stop_watch_gen #(
  parameter int DVSR = 5000000,
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              clr,
  input  logic              up,
  input  logic              ld,
  input  logic [4*NDIG-1:0] din,
  input  logic              lap,
  output logic [4*NDIG-1:0] d,
  output logic              ovf,
  output logic              zero
);

  localparam int            PW       = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(DVSR - 1);

  logic [PW-1:0]     psc;
  logic              tick;
  logic              step;
  logic [4*NDIG-1:0] cnt;
  logic [NDIG-1:0]   match;
  logic [NDIG-1:0]   dig_zero;

  assign tick = go && (psc == PSC_LAST);
  assign zero = &dig_zero;
  // Down-counting saturates at all zeros: a tick there is simply dropped.
  assign step = tick && (up || !zero);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc <= '0;
    end else if (clr || ld) begin
      psc <= '0;
    end else if (go) begin
      psc <= (psc == PSC_LAST) ? '0 : psc + PW'(1);
    end
  end

  generate
    for (genvar i = 0; i < NDIG; i++) begin : g_digit
      localparam logic [NDIG-1:0] LOWER = NDIG'((1 << i) - 1);
      logic [3:0] digit;
      logic [3:0] din_dig;
      logic [3:0] load_val;
      logic [3:0] inc_val;
      logic [3:0] dec_val;
      logic       carry_in;

      assign din_dig  = din[4*i +: 4];
      assign load_val = (din_dig > 4'd9) ? 4'd9 : din_dig;
      assign inc_val  = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      assign dec_val  = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      assign match[i]    = up ? (digit == 4'd9) : (digit == 4'd0);
      assign dig_zero[i] = (digit == 4'd0);
      // A digit moves when every lower digit is at its wrap value.
      assign carry_in = &(match | ~LOWER);
      assign cnt[4*i +: 4] = digit;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          digit <= 4'd0;
        end else if (clr) begin
          digit <= 4'd0;
        end else if (ld) begin
          digit <= load_val;
        end else if (step && carry_in) begin
          digit <= up ? inc_val : dec_val;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else begin
      ovf <= !clr && !ld && step && up && (&match);
    end
  end

`ifdef STOP_WATCH_GEN_LAP_EN
  logic              frozen;
  logic [4*NDIG-1:0] lap_reg;

  // Captures the pre-tick count since cnt is the register value before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frozen  <= 1'b0;
      lap_reg <= '0;
    end else if (clr) begin
      frozen  <= 1'b0;
      lap_reg <= '0;
    end else if (lap) begin
      if (frozen) begin
        frozen <= 1'b0;
      end else begin
        lap_reg <= cnt;
        frozen  <= 1'b1;
      end
    end
  end

  assign d = frozen ? lap_reg : cnt;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign d = cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stop_watch_gen.sv
`default_nettype none
// Testbench for stop_watch_gen: integer reference model, directed and random scenarios.
module tb_stop_watch_gen;

  localparam int DVSR = 4;
  localparam int NDIG = 3;
  localparam int MAXV = 999;
`ifdef STOP_WATCH_GEN_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              go = 1'b0, clr = 1'b0, up = 1'b1, ld = 1'b0, lap = 1'b0;
  logic [4*NDIG-1:0] din = '0;
  logic [4*NDIG-1:0] d;
  logic              ovf, zero;

  int checks = 0;
  int errors = 0;

  int m_val, m_psc, m_lapv;
  bit m_frozen, m_ovf;

  stop_watch_gen #(.DVSR(DVSR), .NDIG(NDIG)) dut (
    .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up), .ld(ld),
    .din(din), .lap(lap), .d(d), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [4*NDIG-1:0] to_bcd(int v);
    logic [4*NDIG-1:0] r;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(logic [4*NDIG-1:0] x);
    int v, p;
    v = 0;
    p = 1;
    for (int i = 0; i < NDIG; i++) begin
      int n;
      n = int'(x[4*i +: 4]);
      if (n > 9) n = 9;
      v += n * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [4*NDIG-1:0] exp_d();
    return to_bcd(m_frozen ? m_lapv : m_val);
  endfunction

  task automatic model_reset();
    m_val = 0; m_psc = 0; m_lapv = 0; m_frozen = 0; m_ovf = 0;
  endtask

  // Behavioural view: the count is a decimal integer, the prescaler a plain counter.
  task automatic model_step();
    bit tk;
    if (reset) begin
      model_reset();
      return;
    end
    tk = go && (m_psc == DVSR - 1);
    m_ovf = 0;
    if (clr) begin
      m_val = 0; m_psc = 0; m_frozen = 0;
    end else begin
      if (LAP_EN && lap) begin
        if (m_frozen) m_frozen = 0;
        else begin
          m_lapv = m_val;
          m_frozen = 1;
        end
      end
      if (ld) begin
        m_val = clamp_val(din);
        m_psc = 0;
      end else begin
        if (go) m_psc = tk ? 0 : m_psc + 1;
        if (tk) begin
          if (up) begin
            if (m_val == MAXV) begin
              m_val = 0;
              m_ovf = 1;
            end else m_val++;
          end else if (m_val > 0) m_val--;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    checks++; if (d !== '0) begin errors++; $display("FAIL reset_d got %h want %h", d, 12'h000); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
    reset = 1'b0;
  endtask

  task automatic test_count_up();
    int ovf_seen = 0;
    clr = 1'b1; go = 1'b0;
    cycle();
    clr = 1'b0; go = 1'b1; up = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (ovf !== 1'b0) ovf_seen++;
      checks++; if (d !== exp_d()) begin errors++; $display("FAIL up_d got %h want %h", d, exp_d()); end
      checks++; if (zero !== (m_val == 0)) begin errors++; $display("FAIL up_zero got %b want %b", zero, m_val == 0); end
    end
    checks++; if (d !== 12'h010) begin errors++; $display("FAIL up_final got %h want 010", d); end
    checks++; if (ovf_seen != 0) begin errors++; $display("FAIL up_ovf got %0d pulses want 0", ovf_seen); end
  endtask

  task automatic test_wrap();
    ld = 1'b1; din = 12'h999; up = 1'b1; go = 1'b1;
    cycle();
    ld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_pre_ovf got %b want 0", ovf); end
    end
    cycle();
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL wrap_d got %h want 000", d); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf got %b want 1", ovf); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL wrap_zero got %b want 1", zero); end
    cycle();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf_after got %b want 0", ovf); end
  endtask

  task automatic test_count_down();
    ld = 1'b1; din = 12'h010; up = 1'b0; go = 1'b1;
    cycle();
    ld = 1'b0;
    repeat (4) cycle();
    checks++; if (d !== 12'h009) begin errors++; $display("FAIL down_first got %h want 009", d); end
    repeat (40) cycle();
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL down_zero_d got %h want 000", d); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL down_zero got %b want 1", zero); end
    for (int k = 0; k < 20; k++) begin
      cycle();
      checks++; if (d !== 12'h000 || ovf !== 1'b0) begin errors++; $display("FAIL down_sat got d=%h ovf=%b want d=000 ovf=0", d, ovf); end
    end
  endtask

  task automatic test_clamp_pause();
    ld = 1'b1; din = 12'h0A5; go = 1'b0;
    cycle();
    ld = 1'b0;
    checks++; if (d !== 12'h095) begin errors++; $display("FAIL clamp got %h want 095", d); end
    for (int k = 0; k < 50; k++) begin
      cycle();
      checks++; if (d !== 12'h095) begin errors++; $display("FAIL pause got %h want 095", d); end
    end
  endtask

  task automatic test_clr_tick();
    int guard = 0;
    ld = 1'b1; din = 12'h123; go = 1'b1; up = 1'b1;
    cycle();
    ld = 1'b0;
    while (m_psc != DVSR - 1 && guard < 10) begin
      cycle();
      guard++;
    end
    checks++; if (d !== 12'h123) begin errors++; $display("FAIL clr_pre got %h want 123", d); end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    checks++; if (d !== 12'h000 || zero !== 1'b1) begin errors++; $display("FAIL clr_tick got d=%h zero=%b want 000/1", d, zero); end
    repeat (3) cycle();
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL clr_no_early_tick got %h want 000", d); end
    cycle();
    checks++; if (d !== 12'h001) begin errors++; $display("FAIL clr_next_tick got %h want 001", d); end
  endtask

  task automatic test_lap();
    clr = 1'b1; go = 1'b0;
    cycle();
    clr = 1'b0; go = 1'b1; up = 1'b1;
    repeat (20) cycle();
    checks++; if (d !== 12'h005) begin errors++; $display("FAIL lap_pre got %h want 005", d); end
    lap = 1'b1;
    cycle();
    lap = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      checks++; if (d !== exp_d()) begin errors++; $display("FAIL lap_hold got %h want %h", d, exp_d()); end
    end
    if (LAP_EN) begin
      checks++; if (d !== 12'h005) begin errors++; $display("FAIL lap_frozen got %h want 005", d); end
    end
    lap = 1'b1;
    cycle();
    lap = 1'b0;
    checks++; if (d !== to_bcd(m_val)) begin errors++; $display("FAIL lap_release got %h want %h", d, to_bcd(m_val)); end
    checks++; if (zero !== (m_val == 0)) begin errors++; $display("FAIL lap_zero got %b want %b", zero, m_val == 0); end
  endtask

  task automatic test_async_reset();
    go = 1'b1; up = 1'b1;
    lap = 1'b1;
    cycle();
    lap = 1'b0;
    repeat (9) cycle();
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL async_reset_d got %h want 000", d); end
    checks++; if (zero !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL async_reset_flags got zero=%b ovf=%b want 1/0", zero, ovf); end
    cycle();
    reset = 1'b0;
    repeat (8) cycle();
    checks++; if (d !== exp_d()) begin errors++; $display("FAIL post_reset got %h want %h", d, exp_d()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      go  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 79) == 0);
      lap = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) up = ~up;
      case ($urandom_range(0, 3))
        0: din = 12'h998;
        1: din = 12'h001;
        default: din = 12'($urandom);
      endcase
      cycle();
      checks++; if (d !== exp_d()) begin errors++; $display("FAIL rand_d cyc %0d got %h want %h", k, d, exp_d()); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc %0d got %b want %b", k, ovf, m_ovf); end
      checks++; if (zero !== (m_val == 0)) begin errors++; $display("FAIL rand_zero cyc %0d got %b want %b", k, zero, m_val == 0); end
    end
    go = 1'b0; clr = 1'b0; ld = 1'b0; lap = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count_up();
    test_wrap();
    test_count_down();
    test_clamp_pause();
    test_clr_tick();
    test_lap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
